// File: rtl/ser_load_ctrl_if.sv
// Bus bundle for the serial word loader.
//   master: drives start, abort, sdi, sdi_valid; observes count, wr_en, bit_out, busy, done
//   slave : the loader itself (ser_load_ctrl)
interface ser_load_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             abort;
    logic             sdi;
    logic             sdi_valid;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             bit_out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, sdi, sdi_valid,
        input  count, wr_en, bit_out, busy, done
    );

    modport slave (
        input  start, abort, sdi, sdi_valid,
        output count, wr_en, bit_out, busy, done
    );
endinterface

// File: rtl/ser_load_ctrl.sv
// Serial word loader: accepts WORD_BITS serial bits (LSB first) and emits one
// registered write strobe per accepted bit together with its bit index, for a
// downstream demultiplexer. Pulses done for one cycle after the last strobe.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   bus      : ser_load_ctrl_if.slave
//              in : start, abort, sdi, sdi_valid
//              out: count (bit index), wr_en, bit_out, busy, done (all registered)
module ser_load_ctrl #(
    parameter int unsigned WORD_BITS = 16,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    ser_load_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BITS - 1);

    state_t           state_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en_q;
    logic             bit_out_q;
    logic             busy_q;
    logic             done_q;
    // Set on acceptance of the last bit: the final strobe cycle is still LOAD,
    // so the done pulse lands in the following cycle rather than on the strobe.
    logic             last_q;

    logic start_ok;

    // abort blocks a start sampled in the same cycle
    assign start_ok = bus.start && !bus.abort;

    // Loader FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            bit_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (last_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        last_q  <= 1'b0;
                    end else if (bus.sdi_valid) begin
                        bit_out_q <= bus.sdi;
                        count_q   <= idx_q;
                        wr_en_q   <= 1'b1;
                        // modulo wrap back to 0 after the last bit
                        idx_q     <= idx_q + CNT_W'(1);
                        if (idx_q == LAST_IDX) begin
                            last_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start_ok) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = count_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.bit_out = bit_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_ser_load_ctrl.sv
// Directed bench for ser_load_ctrl: expected (index, bit) pairs are queued as
// bits are driven and checked against every write strobe.
module tb_ser_load_ctrl;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic             b;
    } exp_t;

    logic clk;
    logic rst;

    ser_load_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ser_load_ctrl #(.WORD_BITS(16), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      errors = 0;
    int unsigned      checks = 0;
    int unsigned      done_cnt = 0;
    int unsigned      strobes = 0;
    exp_t             exp_q[$];
    logic [CNT_W-1:0] exp_idx;
    logic [15:0]      word_cap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.wr_en) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_en", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("count", 32'(bus.count), 32'(e.idx));
                    chk("bit_out", 32'(bus.bit_out), 32'(e.b));
                    word_cap[bus.count] = bus.bit_out;
                end
                chk("wr_en_outside_busy", 32'(bus.busy), 32'd1);
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_with_wr_en", 32'(bus.wr_en), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.sdi       = b;
        bus.sdi_valid = 1'b1;
        exp_q.push_back('{idx: exp_idx, b: b});
        exp_idx = exp_idx + 4'd1;
        tick();
        bus.sdi_valid = 1'b0;
    endtask

    // start_mode: 0 start low during load, 1 held high, 2 random while busy.
    // Returns in the done cycle.
    task automatic load_word(input logic [15:0] w, input logic gaps, input int start_mode);
        exp_idx  = '0;
        word_cap = '0;
        strobes  = 0;
        bus.start = 1'b1;
        tick();
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (start_mode == 2) bus.start = 1'($urandom_range(0, 1));
            else bus.start = (start_mode == 1);
            send_bit(w[i]);
            if (gaps && i < 15) begin
                bus.sdi = ~w[i];
                tick();
                if (i == 3 || i == 10) begin
                    chk("gap_wr_en", 32'(bus.wr_en), 32'd0);
                    chk("gap_count_hold", 32'(bus.count), 32'(i));
                end
            end
        end
        bus.start = (start_mode == 1);
        tick();
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_wr_en_low", 32'(bus.wr_en), 32'd0);
        chk("done_busy_low", 32'(bus.busy), 32'd0);
        chk("word", 32'(word_cap), 32'(w));
        chk("strobes_per_word", strobes, 32'd16);
    endtask

    int unsigned d0;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sdi = 1'b0;
        bus.sdi_valid = 1'b0;
        exp_idx = '0;
        word_cap = '0;
        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_bit_out", 32'(bus.bit_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // valid bits in IDLE are ignored
        bus.sdi = 1'b1;
        bus.sdi_valid = 1'b1;
        tick();
        tick();
        bus.sdi_valid = 1'b0;
        chk("idle_valid_ignored", 32'(bus.wr_en), 32'd0);

        // plain word, contiguous bits
        d0 = done_cnt;
        load_word(16'hA5C3, 1'b0, 0);
        tick();
        chk("idle_after_done", 32'(bus.done), 32'd0);
        chk("done_once_plain", done_cnt, d0 + 1);

        // same word with a gap after every bit
        d0 = done_cnt;
        load_word(16'hA5C3, 1'b1, 0);
        tick();
        chk("done_once_gapped", done_cnt, d0 + 1);

        // abort together with the 8th bit
        d0 = done_cnt;
        exp_idx = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        bus.sdi = 1'b1;
        bus.sdi_valid = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.sdi_valid = 1'b0;
        bus.abort = 1'b0;
        chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        load_word(16'h1234, 1'b0, 0);
        tick();

        // start held through done: back-to-back words
        d0 = done_cnt;
        load_word(16'hA5C3, 1'b0, 1);
        load_word(16'h3C5A, 1'b0, 0);
        bus.start = 1'b0;
        tick();
        chk("done_twice_b2b", done_cnt, d0 + 2);

        // asynchronous reset in the middle of a word
        d0 = done_cnt;
        exp_idx = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        #6;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("arst_bit_out", 32'(bus.bit_out), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_queue_drained", 32'(exp_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        load_word(16'hBEEF, 1'b0, 0);
        tick();
        chk("arst_single_done", done_cnt, d0 + 1);

        // start toggling while busy, with gaps
        d0 = done_cnt;
        load_word(16'h5AA5, 1'b1, 2);
        tick();
        chk("done_once_toggle", done_cnt, d0 + 1);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ser_load_ctrl.md
SER_LOAD_CTRL -- requirements
Module: ser_load_ctrl

Interface
REQ-001 Parameter WORD_BITS, default 16, number of serial bits per word; SHALL equal 2**CNT_W.
REQ-002 Parameter CNT_W, default 4, width of the bit-index output COUNT.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  request to begin loading one word; sampled in IDLE or DONE state only.
REQ-006 ABORT  input  1  cancel current load; synchronous.
REQ-007 SDI  input  1  serial data bit, LSB (index 0) first.
REQ-008 SDI_VALID  input  1  SDI holds a valid bit this cycle.
REQ-009 COUNT  output  CNT_W  bit index of the bit on BIT_OUT; feeds the downstream demultiplexer select.
REQ-010 WR_EN  output  1  one-cycle strobe: BIT_OUT is to be written at position COUNT.
REQ-011 BIT_OUT  output  1  registered copy of the accepted SDI bit.
REQ-012 BUSY  output  1  high while in LOAD state.
REQ-013 DONE  output  1  one-cycle pulse: full word delivered.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DONE; all outputs SHALL be registered (driven from flops, no combinational path from inputs).
REQ-015 IDLE: START=1 -> LOAD on next edge; internal index idx cleared to 0; otherwise stay IDLE.
REQ-016 LOAD: an edge with SDI_VALID=1 and ABORT=0 SHALL set BIT_OUT<=SDI, COUNT<=idx, WR_EN<=1, idx<=idx+1 (one-cycle latency from SDI to BIT_OUT/WR_EN).
REQ-017 LOAD: an edge with SDI_VALID=0 SHALL set WR_EN<=0 and hold COUNT, BIT_OUT, idx; gaps of any length SHALL be tolerated.
REQ-018 WR_EN SHALL be high for exactly one cycle per accepted bit and never outside those cycles.
REQ-019 Acceptance of the bit at idx=WORD_BITS-1 SHALL move FSM to DONE; idx wraps to 0 (CNT_W-bit modulo arithmetic, no overflow flag).
REQ-020 DONE state lasts exactly one cycle with DONE=1 and WR_EN=0; the final WR_EN pulse (COUNT=WORD_BITS-1) is coincident with DONE=1... no -- final WR_EN SHALL be in the cycle immediately preceding the DONE=1 cycle.
REQ-021 From DONE: START=1 -> LOAD (back-to-back words, idx=0); START=0 -> IDLE.
REQ-022 START while in LOAD SHALL be ignored.
REQ-023 ABORT=1 in LOAD SHALL force IDLE next edge, WR_EN<=0, idx<=0, no DONE pulse; ABORT wins over simultaneous SDI_VALID (bit discarded).
REQ-024 ABORT in IDLE or DONE SHALL have no effect other than blocking START in that same cycle (ABORT wins over START).
REQ-025 BUSY SHALL be 1 exactly in cycles where FSM state is LOAD.
REQ-026 SDI_VALID outside LOAD SHALL be ignored (no WR_EN, idx unchanged).

Reset
REQ-027 RST=1 SHALL immediately (without clock) force state IDLE, idx=0, COUNT=0, WR_EN=0, BIT_OUT=0, BUSY=0, DONE=0.
REQ-028 RST asserted mid-load SHALL discard the partial word; no DONE pulse after release.
REQ-029 After RST deasserts, first START SHALL be honoured on the first rising edge.

Verification
REQ-030 START pulse, then 16 consecutive SDI_VALID cycles with SDI=pattern 0xA5C3 LSB first -> WR_EN 16 consecutive cycles, COUNT 0..15, BIT_OUT matches pattern bit, DONE=1 one cycle after COUNT=15 strobe; downstream word reads 0xA5C3.
REQ-031 Same word with SDI_VALID low every other cycle -> WR_EN pulses only on valid cycles, COUNT holds between, final word identical, DONE once.
REQ-032 ABORT asserted together with 8th valid bit -> no WR_EN for that bit, FSM IDLE, BUSY=0, no DONE; subsequent full load yields COUNT starting at 0.
REQ-033 START held high through DONE -> second word begins immediately, BUSY low only during the single DONE cycle, COUNT restarts at 0.
REQ-034 RST pulsed asynchronously (between edges) at idx=5 -> all outputs 0 before next edge; START afterwards loads from COUNT=0.
REQ-035 SDI_VALID toggling and START high while BUSY -> START ignored, no extra WR_EN, exactly 16 strobes per word.
